cla_sub32_pipe: RTL and testbench

//  Pipelined 32-bit subtractor (a - b) built from two 16-bit CLA halves; counterpart to the registered CLA adder.

---
 rtl/cla_sub32_pipe_pkg.sv | 17 +
 rtl/cla_sub32_pipe_cla.sv | 49 ++++
 rtl/cla_sub32_pipe.sv | 133 +++++++++++++
 tb/tb_cla_sub32_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_sub32_pipe_pkg.sv
// Shared constants and types for the pipelined CLA subtractor.
package cla_sub32_pipe_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_HALF  = CLA_WIDTH / 2;
  // Bits per lookahead group inside one CLA half.
  localparam int CLA_GROUP = 4;

  // Result flags registered alongside the difference.
  typedef struct packed {
    logic borrow;
    logic ovf;
    logic zero;
    logic neg;
  } sub_flags_t;

endpackage

// File: rtl/cla_sub32_pipe_cla.sv
// Combinational carry-lookahead adder: group generate/propagate over
// CLA_GROUP-bit groups, with a lookahead carry chained between groups.
module cla_sub32_pipe_cla
  import cla_sub32_pipe_pkg::*;
#(
  parameter int WIDTH = CLA_HALF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Per-group sum bits and group G/P; group carry-out is G | P & carry-in.
  always_comb begin : cla_comb
    logic carry;
    logic c_bit;
    logic grp_g;
    logic grp_p;
    sum   = '0;
    carry = cin;
    c_bit = 1'b0;
    grp_g = 1'b0;
    grp_p = 1'b1;
    for (int base = 0; base < WIDTH; base += CLA_GROUP) begin
      c_bit = carry;
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int j = 0; j < CLA_GROUP; j++) begin
        if (base + j < WIDTH) begin
          sum[base+j] = p[base+j] ^ c_bit;
          c_bit       = g[base+j] | (p[base+j] & c_bit);
          grp_g       = g[base+j] | (p[base+j] & grp_g);
          grp_p       = grp_p & p[base+j];
        end
      end
      carry = grp_g | (grp_p & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/cla_sub32_pipe.sv
// Two-stage pipelined subtractor a - b = a + ~b + 1. Stage 1 computes the
// low half and keeps its carry; stage 2 finishes the high half and the flags.
// Valid/ready on both sides, one operation per clock, 2-edge latency.
module cla_sub32_pipe
  import cla_sub32_pipe_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int HALF = WIDTH / 2;

  // Signed-overflow and borrow/zero/neg flags from the full difference.
  function automatic sub_flags_t calc_flags(input logic [WIDTH-1:0] diff,
                                            input logic             c_w,
                                            input logic             a_msb,
                                            input logic             b_msb);
    sub_flags_t f;
    f.borrow = ~c_w;
    f.ovf    = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
    f.zero   = (diff == '0);
    f.neg    = diff[WIDTH-1];
    return f;
  endfunction

  logic vld_p1;
  logic vld_p2;
  logic s2_free;
  logic accept;
  logic adv_p1;

  assign s2_free  = !vld_p2 || out_ready;
  assign adv_p1   = vld_p1 && s2_free;
  assign in_ready = !vld_p1 || s2_free;
  assign accept   = in_valid && in_ready;

  // ---- stage 1: low half with cin=1 ----
  logic [HALF-1:0] nb_lo;
  logic [HALF-1:0] d_lo;
  logic            c_h;

  assign nb_lo = ~in_b[HALF-1:0];

  cla_sub32_pipe_cla #(.WIDTH(HALF)) u_cla_lo (
    .a    (in_a[HALF-1:0]),
    .b    (nb_lo),
    .cin  (1'b1),
    .sum  (d_lo),
    .cout (c_h)
  );

  logic [HALF-1:0]       d_lo_p1;
  logic                  c_h_p1;
  logic [WIDTH-HALF-1:0] a_hi_p1;
  logic [WIDTH-HALF-1:0] nb_hi_p1;
  logic                  a_msb_p1;
  logic                  b_msb_p1;

  // Capture low-half result and high-half operands on accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      d_lo_p1  <= d_lo;
      c_h_p1   <= c_h;
      a_hi_p1  <= in_a[WIDTH-1:HALF];
      nb_hi_p1 <= ~in_b[WIDTH-1:HALF];
      a_msb_p1 <= in_a[WIDTH-1];
      b_msb_p1 <= in_b[WIDTH-1];
    end
  end

  // ---- stage 2: high half with carry from the low half ----
  logic [WIDTH-HALF-1:0] d_hi;
  logic                  c_w;
  logic [WIDTH-1:0]      diff_full;

  cla_sub32_pipe_cla #(.WIDTH(WIDTH - HALF)) u_cla_hi (
    .a    (a_hi_p1),
    .b    (nb_hi_p1),
    .cin  (c_h_p1),
    .sum  (d_hi),
    .cout (c_w)
  );

  assign diff_full = {d_hi, d_lo_p1};

  logic [WIDTH-1:0] diff_p2;
  sub_flags_t       flags_p2;

  // Result registers load only when stage 1 advances; reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      diff_p2  <= '0;
      flags_p2 <= '0;
    end else if (adv_p1) begin
      diff_p2  <= diff_full;
      flags_p2 <= calc_flags(diff_full, c_w, a_msb_p1, b_msb_p1);
    end
  end

  // Valid bits: stage 1 fills on accept and empties on advance; stage 2
  // follows stage 1 whenever it is free to take a new entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (accept)      vld_p1 <= 1'b1;
      else if (adv_p1) vld_p1 <= 1'b0;
      if (s2_free)     vld_p2 <= vld_p1;
    end
  end

  assign out_valid  = vld_p2;
  assign out_diff   = diff_p2;
  assign out_borrow = flags_p2.borrow;
  assign out_ovf    = flags_p2.ovf;
  assign out_zero   = flags_p2.zero;
  assign out_neg    = flags_p2.neg;

endmodule

// File: tb/tb_cla_sub32_pipe.sv
// Directed bench for the pipelined subtractor: single ops with flags,
// back-to-back streaming, output backpressure and mid-flight reset.
module tb_cla_sub32_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_diff;
  logic        out_borrow;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic [31:0] vd [8];

  int          iss;
  int          rcv;
  logic        prev_stall;
  logic        hs_in;
  logic        hs_out;
  logic [31:0] held;

  always #5 clock = ~clock;

  cla_sub32_pipe #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_borrow (out_borrow),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .out_neg    (out_neg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One isolated operation: latency, result and flags, then drain.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic eb, input logic eo,
                        input logic ez, input logic en);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, in_ready, 1);
    tick;
    in_valid = 1'b0;
    #1;
    chk({tag, ".lat1"}, out_valid, 0);
    tick;
    #1;
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".diff"}, out_diff, exp_d);
    chk({tag, ".flags"}, {out_borrow, out_ovf, out_zero, out_neg}, {eb, eo, ez, en});
    tick;
    #1;
    chk({tag, ".drained"}, out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    va[0] = 32'h0000_0010; vb[0] = 32'h0000_0001; vd[0] = 32'h0000_000F;
    va[1] = 32'h1234_5678; vb[1] = 32'h0204_0608; vd[1] = 32'h1030_5070;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0001; vd[2] = 32'hFFFF_FFFE;
    va[3] = 32'h0000_0000; vb[3] = 32'h8000_0000; vd[3] = 32'h8000_0000;
    va[4] = 32'hAAAA_5555; vb[4] = 32'h5555_AAAA; vd[4] = 32'h5554_AAAB;
    va[5] = 32'h0010_0000; vb[5] = 32'h000F_FFFF; vd[5] = 32'h0000_0001;
    va[6] = 32'hDEAD_BEEF; vb[6] = 32'hDEAD_BEEF; vd[6] = 32'h0000_0000;
    va[7] = 32'h0000_0100; vb[7] = 32'h0000_0200; vd[7] = 32'hFFFF_FF00;

    // Reset state
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    tick;
    tick;
    chk("rst.valid", out_valid, 0);
    chk("rst.diff", out_diff, 0);
    chk("rst.flags", {out_borrow, out_ovf, out_zero, out_neg}, 4'b0000);
    reset = 1'b0;
    tick;
    chk("rst.in_ready", in_ready, 1);

    // T1..T4 single operations {borrow, ovf, zero, neg}
    single("t1", 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 0, 0, 0, 0);
    single("t2a", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1, 0, 0, 1);
    single("t2b", 32'h1234_ABCD, 32'h1234_ABCD, 32'h0000_0000, 0, 0, 1, 0);
    single("t3a", 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 0, 0);
    single("t3b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 0, 1);
    single("t4x", 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 0, 0, 0, 0);
    single("t4y", 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1, 1, 0, 1);

    // T4 back-to-back stream: one result per cycle, in order
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        in_a     = va[i];
        in_b     = vb[i];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 8) chk("t4.in_ready", in_ready, 1);
      if (i >= 2) begin
        chk("t4.valid", out_valid, 1);
        chk("t4.diff", out_diff, vd[i-2]);
      end
      tick;
    end
    #1;
    chk("t4.drained", out_valid, 0);

    // T5 backpressure: out_ready low for the first 3 cycles
    iss        = 0;
    rcv        = 0;
    prev_stall = 1'b0;
    held       = '0;
    for (int cyc = 0; cyc < 30 && rcv < 4; cyc++) begin
      out_ready = (cyc >= 3);
      in_valid  = (iss < 4);
      if (iss < 4) begin
        in_a = va[iss];
        in_b = vb[iss];
      end
      #1;
      if (prev_stall) chk("t5.hold", out_diff, held);
      if (cyc == 2) chk("t5.full", in_ready, 0);
      prev_stall = out_valid && !out_ready;
      held       = out_diff;
      hs_in      = in_valid && in_ready;
      hs_out     = out_valid && out_ready;
      if (hs_out) begin
        chk("t5.diff", out_diff, vd[rcv]);
        rcv++;
      end
      tick;
      if (hs_in) iss++;
    end
    in_valid = 1'b0;
    #1;
    chk("t5.issued", iss, 4);
    chk("t5.received", rcv, 4);
    chk("t5.no_dup", out_valid, 0);

    // T6 reset with two operations in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = va[1];
    in_b      = vb[1];
    tick;
    in_a = va[2];
    in_b = vb[2];
    tick;
    in_valid = 1'b0;
    #1;
    chk("t6.full", out_valid, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("t6.valid", out_valid, 0);
    chk("t6.diff", out_diff, 0);
    chk("t6.in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t6.no_stale", out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
